// File: rtl/keypad_pkg.sv
// Shared types and key map for the PmodKYPD keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_ONE   = 2'd1,
    FR_MULTI = 2'd2
  } frame_res_e;

  typedef logic [1:0] row_idx_t;
  typedef logic [1:0] col_idx_t;

  // Indexed by {row, col}; row 0 is the top row of the keypad.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic [3:0] key_map(input row_idx_t r, input col_idx_t c);
    return KEY_MAP[{r, c}];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a new frame result must repeat DEBOUNCE_FRAMES times
// before it replaces the stable state; reports each accepted change.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_done,
  input  frame_res_e i_res,
  input  logic [3:0] i_code,
  output frame_res_e o_stable_res,
  output logic [3:0] o_stable_code,
  output logic       o_change,
  output logic       o_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);

  frame_res_e    r_stable_res, r_cand_res;
  logic [3:0]    r_stable_code, r_cand_code;
  logic [CW-1:0] r_cnt;
  logic          r_change, r_press;

  frame_res_e    w_stable_res, w_cand_res;
  logic [3:0]    w_stable_code, w_cand_code, w_code_eff;
  logic [CW-1:0] w_cnt;
  logic          w_change, w_press;

  always_comb begin
    w_stable_res  = r_stable_res;
    w_stable_code = r_stable_code;
    w_cand_res    = r_cand_res;
    w_cand_code   = r_cand_code;
    w_cnt         = r_cnt;
    w_change      = 1'b0;
    w_press       = 1'b0;
    // Code is only meaningful for ONE; forcing it to zero otherwise keeps
    // NONE/MULTI comparisons independent of stale codes.
    w_code_eff    = (i_res == FR_ONE) ? i_code : '0;
    if (i_frame_done) begin
      if (i_res == r_stable_res && w_code_eff == r_stable_code) begin
        w_cnt = '0;
      end else begin
        if (i_res == r_cand_res && w_code_eff == r_cand_code) begin
          w_cnt = r_cnt + CW'(1);
        end else begin
          w_cand_res  = i_res;
          w_cand_code = w_code_eff;
          w_cnt       = CW'(1);
        end
        if (w_cnt == CW'(DEBOUNCE_FRAMES)) begin
          w_stable_res  = w_cand_res;
          w_stable_code = w_cand_code;
          w_cnt         = '0;
          w_change      = 1'b1;
          w_press       = (r_stable_res == FR_NONE) && (w_cand_res == FR_ONE);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_res  <= FR_NONE;
      r_stable_code <= '0;
      r_cand_res    <= FR_NONE;
      r_cand_code   <= '0;
      r_cnt         <= '0;
      r_change      <= 1'b0;
      r_press       <= 1'b0;
    end else begin
      r_stable_res  <= w_stable_res;
      r_stable_code <= w_stable_code;
      r_cand_res    <= w_cand_res;
      r_cand_code   <= w_cand_code;
      r_cnt         <= w_cnt;
      r_change      <= w_change;
      r_press       <= w_press;
    end
  end

  assign o_stable_res  = r_stable_res;
  assign o_stable_code = r_stable_code;
  assign o_change      = r_change;
  assign o_press       = r_press;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sequencing, row synchronization, frame
// classification, and a single-cycle strobe per debounced key press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = 100_000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned   TW        = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

  logic [3:0]    r_row_meta, r_row_sync;
  logic [TW-1:0] r_tick;
  col_idx_t      r_col_idx;
  logic [1:0]    r_hits;
  logic [3:0]    r_code;
  logic          r_frame_done;
  frame_res_e    r_frame_res;
  logic [3:0]    r_frame_code;
  logic [3:0]    r_key_code;
  logic          r_key_valid, r_key_held;

  logic          w_sample;
  logic [2:0]    w_col_hits, w_total;
  logic [1:0]    w_hits_sat;
  logic [3:0]    w_col_code, w_code_next;
  frame_res_e    w_frame_res;
  frame_res_e    w_stable_res;
  logic [3:0]    w_stable_code;
  logic          w_change, w_press;

  assign w_sample = (r_tick == TICK_LAST);

  // Hit count saturates at 2: the frame only needs to tell none/one/many.
  always_comb begin
    w_col_hits = '0;
    w_col_code = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!r_row_sync[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_col_code = key_map(row_idx_t'(r), r_col_idx);
      end
    end
    w_total     = {1'b0, r_hits} + w_col_hits;
    w_hits_sat  = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
    w_code_next = (w_col_hits != '0) ? w_col_code : r_code;
    unique case (w_hits_sat)
      2'd0:    w_frame_res = FR_NONE;
      2'd1:    w_frame_res = FR_ONE;
      default: w_frame_res = FR_MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_meta   <= '1;
      r_row_sync   <= '1;
      r_tick       <= '0;
      r_col_idx    <= '0;
      r_hits       <= '0;
      r_code       <= '0;
      r_frame_done <= 1'b0;
      r_frame_res  <= FR_NONE;
      r_frame_code <= '0;
    end else begin
      r_row_meta   <= row;
      r_row_sync   <= r_row_meta;
      r_frame_done <= 1'b0;
      if (w_sample) begin
        r_tick    <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          r_frame_done <= 1'b1;
          r_frame_res  <= w_frame_res;
          r_frame_code <= w_code_next;
          r_hits       <= '0;
          r_code       <= '0;
        end else begin
          r_hits <= w_hits_sat;
          r_code <= w_code_next;
        end
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .i_frame_done (r_frame_done),
    .i_res        (r_frame_res),
    .i_code       (r_frame_code),
    .o_stable_res (w_stable_res),
    .o_stable_code(w_stable_code),
    .o_change     (w_change),
    .o_press      (w_press)
  );

  // Held only survives while stable stays the same ONE(k) it was set by.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= w_press;
      if (w_press) r_key_code <= w_stable_code;
      r_key_held  <= w_press | (r_key_held & ~w_change & (w_stable_res == FR_ONE));
    end
  end

  assign col       = ~(4'b0001 << r_col_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

  localparam int unsigned ST    = 8;
  localparam int unsigned DF    = 3;
  localparam int unsigned FRAME = 4 * ST;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  bit [15:0]  pressed = '0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_strobes = 0;
  int         cyc = 0;
  int         strobe_cyc = 0;
  logic [3:0] last_code = '0;
  logic       prev_valid = 1'b0;

  keypad_scanner #(
    .SCAN_TICKS     (ST),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      check("no_back_to_back_strobe", 32'(prev_valid), 32'd0);
      n_strobes++;
      last_code  = key_code;
      strobe_cyc = cyc;
    end
    prev_valid = key_valid;
  end

  // Returns #1 after the edge on which column 0 becomes active.
  task automatic align();
    logic [3:0] prev;
    prev = col;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (col == 4'b1110 && prev == 4'b0111) return;
      prev = col;
    end
    check("align_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         k;
    logic [3:0] col;
  } col_vec_t;

  typedef struct {
    int         idx;
    logic [3:0] code;
  } key_vec_t;

  col_vec_t col_tab[7];
  key_vec_t key_tab[7];

  initial begin
    int c0, base, lat;

    col_tab[0] = '{4,  4'b1110};
    col_tab[1] = '{7,  4'b1110};
    col_tab[2] = '{8,  4'b1101};
    col_tab[3] = '{12, 4'b1101};
    col_tab[4] = '{20, 4'b1011};
    col_tab[5] = '{28, 4'b0111};
    col_tab[6] = '{36, 4'b1110};

    key_tab[0] = '{1*4+2, 4'h6};
    key_tab[1] = '{0*4+0, 4'h1};
    key_tab[2] = '{3*4+3, 4'hD};
    key_tab[3] = '{0*4+3, 4'hA};
    key_tab[4] = '{2*4+1, 4'h8};
    key_tab[5] = '{3*4+1, 4'hF};
    key_tab[6] = '{1*4+0, 4'h4};

    // Reset state and idle column sequence
    repeat (3) @(posedge clk);
    #1;
    check("rst_col",   32'(col),       32'hE);
    check("rst_code",  32'(key_code),  32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held",  32'(key_held),  32'h0);
    rst = 1'b0;
    c0  = cyc;
    for (int i = 0; i < 7; i++) begin
      while (cyc - c0 < col_tab[i].k) wait_cycles(1);
      check($sformatf("col_seq_k%0d", col_tab[i].k), 32'(col), 32'(col_tab[i].col));
    end
    wait_cycles(4 * FRAME);
    check("idle_no_strobe", 32'(n_strobes), 32'd0);
    check("idle_held",      32'(key_held),  32'd0);

    // Single key press/release per table entry
    for (int i = 0; i < 7; i++) begin
      align();
      base = n_strobes;
      c0   = cyc;
      pressed = 16'(1) << key_tab[i].idx;
      wait_cycles(6 * FRAME);
      lat = strobe_cyc - c0;
      check($sformatf("press_%0h_strobes", key_tab[i].code), 32'(n_strobes), 32'(base + 1));
      check($sformatf("press_%0h_code", key_tab[i].code),    32'(last_code), 32'(key_tab[i].code));
      check($sformatf("press_%0h_lat_max", key_tab[i].code), 32'(lat <= 4 * FRAME + 4), 32'd1);
      check($sformatf("press_%0h_lat_min", key_tab[i].code), 32'(lat >= DF * FRAME), 32'd1);
      check($sformatf("press_%0h_held", key_tab[i].code),    32'(key_held), 32'd1);
      pressed = '0;
      wait_cycles(2 * FRAME);
      check($sformatf("release_%0h_held_early", key_tab[i].code), 32'(key_held), 32'd1);
      wait_cycles(2 * FRAME);
      check($sformatf("release_%0h_held", key_tab[i].code),    32'(key_held),  32'd0);
      check($sformatf("release_%0h_strobes", key_tab[i].code), 32'(n_strobes), 32'(base + 1));
      check($sformatf("release_%0h_code", key_tab[i].code),    32'(key_code),  32'(key_tab[i].code));
    end

    // Bouncing key (r3,c1), toggled every frame
    align();
    base = n_strobes;
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 16'(1) << 13 : '0;
      wait_cycles(FRAME);
    end
    pressed = '0;
    wait_cycles(4 * FRAME);
    check("bounce_no_strobe", 32'(n_strobes), 32'(base));
    check("bounce_held",      32'(key_held),  32'd0);

    // Two keys, then one released: MULTI -> ONE must not strobe
    align();
    base = n_strobes;
    pressed = 16'b11;
    wait_cycles(5 * FRAME);
    check("multi_no_strobe", 32'(n_strobes), 32'(base));
    pressed = 16'b01;
    wait_cycles(5 * FRAME);
    check("multi_to_one_no_strobe", 32'(n_strobes), 32'(base));
    check("multi_to_one_held",      32'(key_held),  32'd0);
    pressed = '0;
    wait_cycles(4 * FRAME);
    pressed = 16'(1) << 15;
    wait_cycles(5 * FRAME);
    check("after_multi_strobes", 32'(n_strobes), 32'(base + 1));
    check("after_multi_code",    32'(last_code), 32'hD);
    pressed = '0;
    wait_cycles(4 * FRAME);

    // Rollover A -> B rejected
    align();
    base = n_strobes;
    pressed = 16'(1) << 3;
    wait_cycles(5 * FRAME);
    check("roll_a_strobes", 32'(n_strobes), 32'(base + 1));
    check("roll_a_code",    32'(last_code), 32'hA);
    check("roll_a_held",    32'(key_held),  32'd1);
    pressed = 16'(1) << 7;
    wait_cycles(5 * FRAME);
    check("roll_b_no_strobe", 32'(n_strobes), 32'(base + 1));
    check("roll_b_held",      32'(key_held),  32'd0);
    check("roll_b_code_hold", 32'(key_code),  32'hA);
    pressed = '0;
    wait_cycles(4 * FRAME);

    // Reset mid-frame while key 0 is held
    align();
    pressed = 16'(1) << 12;
    wait_cycles(5 * FRAME);
    check("pre_rst_code", 32'(last_code), 32'h0);
    check("pre_rst_held", 32'(key_held),  32'd1);
    wait_cycles(FRAME + 8);
    rst = 1'b1;
    wait_cycles(1);
    check("midrst_col",   32'(col),       32'hE);
    check("midrst_valid", 32'(key_valid), 32'd0);
    check("midrst_held",  32'(key_held),  32'd0);
    check("midrst_code",  32'(key_code),  32'h0);
    rst  = 1'b0;
    c0   = cyc;
    base = n_strobes;
    wait_cycles(4 * FRAME);
    lat = strobe_cyc - c0;
    check("post_rst_strobes", 32'(n_strobes), 32'(base + 1));
    check("post_rst_code",    32'(last_code), 32'h0);
    check("post_rst_held",    32'(key_held),  32'd1);
    check("post_rst_lat",     32'(lat >= DF * FRAME && lat <= DF * FRAME + 4), 32'd1);
    pressed = '0;
    wait_cycles(4 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
